// File: rtl/mba_divider.sv
// mba_divider: 16/8 sequential divider built on a non-restoring shift/add-subtract core.
// IDLE -> CALC (16 steps) -> FIX (correction, overflow, saturation) -> DONE -> IDLE.
// A divide-by-zero request goes straight from IDLE to DONE.
// Optional build macro: SIGNED_DIV_EN selects two's-complement operands. The core
// then divides magnitudes, and the result signs are restored in FIX.
module mba_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [7:0]  q,
  output logic [7:0]  r,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        div0,
  output logic [15:0] io_oeb
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [15:0] acc;    // dividend bits shift out, quotient bits shift in
  logic [9:0]  prem;   // signed partial remainder, always within [-dsr, dsr)
  logic [7:0]  dsr;    // captured divisor (magnitude in signed builds)
  logic [3:0]  cnt;    // CALC step counter
`ifdef SIGNED_DIV_EN
  logic        q_neg;  // quotient sign: operand signs differ
  logic        r_neg;  // remainder sign follows the dividend
`endif

  logic [9:0]  prem_sh;
  logic [9:0]  prem_next;
  logic [7:0]  rem_mag;
  logic [15:0] dvd_mag;
  logic [7:0]  dsr_mag;
  logic [7:0]  div0_q;
  logic [7:0]  q_fix;
  logic [7:0]  r_fix;
  logic        ovf_fix;

  assign io_oeb = 16'h0000;

  // One non-restoring step, final remainder correction, and result formatting.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    prem_sh   = {prem[8:0], acc[15]};
    prem_next = prem[9] ? prem_sh + {2'b00, dsr} : prem_sh - {2'b00, dsr};
    rem_mag   = prem[9] ? prem[7:0] + dsr : prem[7:0];
`ifdef SIGNED_DIV_EN
    dvd_mag = dividend[15] ? 16'h0000 - dividend : dividend;
    dsr_mag = divisor[7]   ? 8'h00 - divisor     : divisor;
    div0_q  = dividend[15] ? 8'h80 : 8'h7F;
    ovf_fix = q_neg ? (acc > 16'd128) : (acc > 16'd127);
    if (ovf_fix) begin
      q_fix = q_neg ? 8'h80 : 8'h7F;
      r_fix = 8'h00;
    end else begin
      q_fix = q_neg ? 8'h00 - acc[7:0] : acc[7:0];
      r_fix = r_neg ? 8'h00 - rem_mag  : rem_mag;
    end
`else
    dvd_mag = dividend;
    dsr_mag = divisor;
    div0_q  = 8'hFF;
    ovf_fix = |acc[15:8];
    q_fix   = ovf_fix ? 8'hFF : acc[7:0];
    r_fix   = ovf_fix ? 8'h00 : rem_mag;
`endif
  end

  // Control FSM with registered outputs and the datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every register, datapath included, is cleared so an aborted divide leaves no residue.
      state <= IDLE;
      acc   <= '0;
      prem  <= '0;
      dsr   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      div0  <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge state.
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The IDLE cycle that carries the done pulse ignores start.
          if (start && !done) begin
            if (divisor == 8'h00) begin
              q     <= div0_q;
              r     <= dividend[7:0];
              div0  <= 1'b1;
              ovf   <= 1'b0;
              state <= DONE;
            end else begin
              acc   <= dvd_mag;
              dsr   <= dsr_mag;
              prem  <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
`ifdef SIGNED_DIV_EN
              q_neg <= dividend[15] ^ divisor[7];
              r_neg <= dividend[15];
`endif
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= prem_next;
          acc  <= {acc[14:0], ~prem_next[9]};
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) state <= FIX;
        end
        FIX: begin
          q     <= q_fix;
          r     <= r_fix;
          ovf   <= ovf_fix;
          div0  <= 1'b0;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
